// File: rtl/dca_matrix_lsu_rdata_aligner_pkg.sv
// rtl/dca_matrix_lsu_rdata_aligner_pkg.sv - shared constants, txn-info field offsets and FSM states
// Used by both builds (DCA_LSU_RDATA_SKID_EN defined or not).
package dca_matrix_lsu_rdata_aligner_pkg;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam int         TXN_ALEN_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_e;

  function automatic int bw_bitaddr(input int bw_axi_data);
    return $clog2(bw_axi_data);
  endfunction

  // Txn info is {flag_a, row_last, alen[7:0], bitaddr}
  function automatic int bw_txn_info(input int bw_axi_data);
    return 2 + TXN_ALEN_W + bw_bitaddr(bw_axi_data);
  endfunction

  function automatic int txn_alen_lsb(input int bw_axi_data);
    return bw_bitaddr(bw_axi_data);
  endfunction

  function automatic int txn_row_last_bit(input int bw_axi_data);
    return bw_bitaddr(bw_axi_data) + TXN_ALEN_W;
  endfunction

  function automatic int txn_flag_a_bit(input int bw_axi_data);
    return bw_bitaddr(bw_axi_data) + TXN_ALEN_W + 1;
  endfunction

endpackage

// File: rtl/dca_lsu_txninfo_fifo.sv
// rtl/dca_lsu_txninfo_fifo.sv - synchronous txn-info FIFO, valid/ready push side, pop/empty read side
// No same-cycle bypass: a push is visible on rdata the cycle after.
module dca_lsu_txninfo_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstnn,
  input  logic             clear,
  input  logic             wvalid,
  output logic             wready,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full;
  logic             push;

  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign wready = !full;
  assign push   = wvalid && !full;
  assign rdata  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push)           wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop && !empty)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstnn || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dca_matrix_lsu_rdata_aligner.sv
// rtl/dca_matrix_lsu_rdata_aligner.sv - collects AXI R beats of one row and shifts out the bit offset
// Optional one-entry output holding register under DCA_LSU_RDATA_SKID_EN.
module dca_matrix_lsu_rdata_aligner
  import dca_matrix_lsu_rdata_aligner_pkg::*;
#(
  parameter int BW_AXI_DATA    = 64,
  parameter int MATRIX_NUM_COL = 4,
  parameter int BW_LSU_ELEMENT = 32,
  parameter int MAX_BEATS      = 3,
  parameter int TXN_FIFO_DEPTH = 4,
  localparam int BW_LSU_ELEMENT_ROW = MATRIX_NUM_COL * BW_LSU_ELEMENT,
  localparam int BW_BITADDR         = bw_bitaddr(BW_AXI_DATA),
  localparam int BW_TXN_INFO        = bw_txn_info(BW_AXI_DATA)
) (
  input  logic                          clk,
  input  logic                          rstnn,
  input  logic                          clear,
  input  logic                          txinfo_wvalid,
  output logic                          txinfo_wready,
  input  logic [BW_TXN_INFO-1:0]        txinfo_wdata,
  input  logic                          rvalid,
  output logic                          rready,
  input  logic [BW_AXI_DATA-1:0]        rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rlast,
  output logic                          row_valid,
  input  logic                          row_ready,
  output logic [BW_LSU_ELEMENT_ROW-1:0] row_data,
  output logic [BW_TXN_INFO-1:0]        row_txn_info,
  output logic                          error
);

  localparam int         BUF_W       = MAX_BEATS * BW_AXI_DATA;
  localparam int         ALEN_LSB    = txn_alen_lsb(BW_AXI_DATA);
  localparam logic [7:0] MAX_BEATS_B = 8'(MAX_BEATS);

  state_e                        state_q, state_d;
  logic [BW_TXN_INFO-1:0]        cur_info_q, cur_info_d;
  logic [7:0]                    beat_cnt_q, beat_cnt_d;
  logic [BUF_W-1:0]              buf_q, buf_d;
  logic                          row_valid_q, row_valid_d;
  logic [BW_LSU_ELEMENT_ROW-1:0] row_data_q, row_data_d;
  logic [BW_TXN_INFO-1:0]        row_txn_info_q, row_txn_info_d;
  logic                          error_q, error_d;

  logic                   fifo_pop;
  logic                   fifo_empty;
  logic [BW_TXN_INFO-1:0] fifo_rdata;
  logic [7:0]             alen;
  logic [BW_BITADDR-1:0]  shift;
  logic                   last_beat;
  logic                   beat_fire;
  logic [BUF_W-1:0]       row_full;

  dca_lsu_txninfo_fifo #(
    .WIDTH (BW_TXN_INFO),
    .DEPTH (TXN_FIFO_DEPTH)
  ) u_txninfo_fifo (
    .clk    (clk),
    .rstnn  (rstnn),
    .clear  (clear),
    .wvalid (txinfo_wvalid),
    .wready (txinfo_wready),
    .wdata  (txinfo_wdata),
    .pop    (fifo_pop),
    .empty  (fifo_empty),
    .rdata  (fifo_rdata)
  );

  assign alen      = cur_info_q[ALEN_LSB +: TXN_ALEN_W];
  assign shift     = {cur_info_q[BW_BITADDR-1:3], 3'b000};
  assign last_beat = (beat_cnt_q == alen);
  assign beat_fire = rvalid && rready;

`ifdef DCA_LSU_RDATA_SKID_EN
  // Hold off the final beat only when the finished row would have nowhere to go
  assign rready = (state_q == ST_COLLECT) && !clear &&
                  !(last_beat && row_valid_q && !row_ready);
`else
  assign rready = (state_q == ST_COLLECT) && !clear;
`endif

  always_comb begin
    state_d        = state_q;
    cur_info_d     = cur_info_q;
    beat_cnt_d     = beat_cnt_q;
    buf_d          = buf_q;
    row_valid_d    = row_valid_q;
    row_data_d     = row_data_q;
    row_txn_info_d = row_txn_info_q;
    error_d        = error_q;
    fifo_pop       = 1'b0;
    row_full       = '0;

`ifdef DCA_LSU_RDATA_SKID_EN
    if (row_valid_q && row_ready) row_valid_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          cur_info_d = fifo_rdata;
          beat_cnt_d = '0;
          buf_d      = '0;
          state_d    = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (beat_fire) begin
          for (int i = 0; i < MAX_BEATS; i++) begin
            if (beat_cnt_q == 8'(i)) buf_d[i*BW_AXI_DATA +: BW_AXI_DATA] = rdata;
          end
          if (beat_cnt_q >= MAX_BEATS_B) error_d = 1'b1;
          if (rresp != AXI_RESP_OKAY)    error_d = 1'b1;
          if (rlast != last_beat)        error_d = 1'b1;
          if (last_beat) begin
            row_full       = buf_d >> shift;
            row_data_d     = row_full[BW_LSU_ELEMENT_ROW-1:0];
            row_txn_info_d = cur_info_q;
            row_valid_d    = 1'b1;
`ifdef DCA_LSU_RDATA_SKID_EN
            if (!fifo_empty) begin
              fifo_pop   = 1'b1;
              cur_info_d = fifo_rdata;
              beat_cnt_d = '0;
              buf_d      = '0;
              state_d    = ST_COLLECT;
            end else begin
              state_d = ST_IDLE;
            end
`else
            state_d = ST_OUTPUT;
`endif
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      ST_OUTPUT: begin
        if (row_ready) begin
          row_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            cur_info_d = fifo_rdata;
            beat_cnt_d = '0;
            buf_d      = '0;
            state_d    = ST_COLLECT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstnn || clear) begin
      state_q        <= ST_IDLE;
      cur_info_q     <= '0;
      beat_cnt_q     <= '0;
      buf_q          <= '0;
      row_valid_q    <= 1'b0;
      row_data_q     <= '0;
      row_txn_info_q <= '0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_info_q     <= cur_info_d;
      beat_cnt_q     <= beat_cnt_d;
      buf_q          <= buf_d;
      row_valid_q    <= row_valid_d;
      row_data_q     <= row_data_d;
      row_txn_info_q <= row_txn_info_d;
      error_q        <= error_d;
    end
  end

  assign row_valid    = row_valid_q;
  assign row_data     = row_data_q;
  assign row_txn_info = row_txn_info_q;
  assign error        = error_q;

endmodule

// File: tb/tb_dca_matrix_lsu_rdata_aligner.sv
// tb/tb_dca_matrix_lsu_rdata_aligner.sv - directed self-checking bench for the rdata aligner
// Targets the default build (DCA_LSU_RDATA_SKID_EN undefined).
module tb_dca_matrix_lsu_rdata_aligner;

  logic         clk = 1'b0;
  logic         rstnn;
  logic         clear;
  logic         txinfo_wvalid;
  logic         txinfo_wready;
  logic [15:0]  txinfo_wdata;
  logic         rvalid;
  logic         rready;
  logic [63:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         row_valid;
  logic         row_ready;
  logic [127:0] row_data;
  logic [15:0]  row_txn_info;
  logic         error;

  int tests = 0;
  int fails = 0;

  dca_matrix_lsu_rdata_aligner dut (
    .clk           (clk),
    .rstnn         (rstnn),
    .clear         (clear),
    .txinfo_wvalid (txinfo_wvalid),
    .txinfo_wready (txinfo_wready),
    .txinfo_wdata  (txinfo_wdata),
    .rvalid        (rvalid),
    .rready        (rready),
    .rdata         (rdata),
    .rresp         (rresp),
    .rlast         (rlast),
    .row_valid     (row_valid),
    .row_ready     (row_ready),
    .row_data      (row_data),
    .row_txn_info  (row_txn_info),
    .error         (error)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mk_info(input logic fa, input logic rl,
                                          input logic [7:0] alen, input logic [5:0] ba);
    return {fa, rl, alen, ba};
  endfunction

  task automatic push_info(input logic [15:0] info);
    txinfo_wvalid = 1'b1;
    txinfo_wdata  = info;
    @(posedge clk);
    @(negedge clk);
    txinfo_wvalid = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [1:0] resp, input logic last);
    int n;
    rdata  = d;
    rresp  = resp;
    rlast  = last;
    rvalid = 1'b1;
    n = 0;
    while (!rready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rready) begin
      tests++; fails++;
      $display("FAIL beat_timeout: rready=%0b after %0d cycles, required 1", rready, n);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  task automatic accept_row();
    row_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    row_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rstnn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstnn = 1'b1;
    @(negedge clk);
    tests++;
    if ({rready, row_valid, error, txinfo_wready} !== 4'b0001) begin
      fails++;
      $display("FAIL reset_ctrl: rready/row_valid/error/wready=%b, required 0001",
               {rready, row_valid, error, txinfo_wready});
    end
    tests++;
    if (row_data !== 128'h0 || row_txn_info !== 16'h0) begin
      fails++;
      $display("FAIL reset_data: row_data=%h info=%h, required 0/0", row_data, row_txn_info);
    end
  endtask

  task automatic test_aligned_two_beat();
    logic [15:0] info;
    info = mk_info(1'b0, 1'b1, 8'd1, 6'd0);
    push_info(info);
    send_beat(64'h1111111111111111, 2'b00, 1'b0);
    tests++;
    if (row_valid !== 1'b0) begin
      fails++;
      $display("FAIL aligned_early_valid: row_valid=%b, required 0", row_valid);
    end
    send_beat(64'h2222222222222222, 2'b00, 1'b1);
    tests++;
    if (row_valid !== 1'b1 || row_data !== 128'h2222222222222222_1111111111111111) begin
      fails++;
      $display("FAIL aligned_row: valid=%b data=%h, required 1 %h", row_valid, row_data,
               128'h2222222222222222_1111111111111111);
    end
    tests++;
    if (row_txn_info !== info || error !== 1'b0) begin
      fails++;
      $display("FAIL aligned_info: info=%h error=%b, required %h 0", row_txn_info, error, info);
    end
    accept_row();
    tests++;
    if (row_valid !== 1'b0) begin
      fails++;
      $display("FAIL aligned_drop: row_valid=%b, required 0", row_valid);
    end
  endtask

  task automatic test_offset_three_beat();
    push_info(mk_info(1'b1, 1'b0, 8'd2, 6'd32));
    send_beat(64'hAAAAAAAA_55555555, 2'b00, 1'b0);
    send_beat(64'hBBBBBBBB_CCCCCCCC, 2'b00, 1'b0);
    send_beat(64'h12345678_9ABCDEF0, 2'b00, 1'b1);
    tests++;
    if (row_valid !== 1'b1 || row_data !== 128'h9ABCDEF0_BBBBBBBB_CCCCCCCC_AAAAAAAA) begin
      fails++;
      $display("FAIL offset_row: valid=%b data=%h, required 1 %h", row_valid, row_data,
               128'h9ABCDEF0_BBBBBBBB_CCCCCCCC_AAAAAAAA);
    end
    tests++;
    if (error !== 1'b0) begin
      fails++;
      $display("FAIL offset_error: error=%b, required 0", error);
    end
    accept_row();
  endtask

  task automatic test_back_to_back();
    logic [15:0] info1, info2;
    info1 = mk_info(1'b0, 1'b0, 8'd0, 6'd8);
    info2 = mk_info(1'b0, 1'b1, 8'd0, 6'd16);
    push_info(info1);
    push_info(info2);
    send_beat(64'h0123456789ABCDEF, 2'b00, 1'b1);
    rvalid = 1'b1;
    rdata  = 64'hFEDCBA9876543210;
    rlast  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (row_valid !== 1'b1 || rready !== 1'b0 ||
          row_data !== 128'h000123456789ABCD || row_txn_info !== info1) begin
        fails++;
        $display("FAIL stall_hold[%0d]: valid=%b rready=%b data=%h info=%h, required 1 0 %h %h",
                 i, row_valid, rready, row_data, row_txn_info, 128'h000123456789ABCD, info1);
      end
      @(negedge clk);
    end
    accept_row();
    send_beat(64'hFEDCBA9876543210, 2'b00, 1'b1);
    tests++;
    if (row_valid !== 1'b1 || row_data !== 128'h0000FEDCBA987654 || row_txn_info !== info2) begin
      fails++;
      $display("FAIL second_row: valid=%b data=%h info=%h, required 1 %h %h",
               row_valid, row_data, row_txn_info, 128'h0000FEDCBA987654, info2);
    end
    accept_row();
  endtask

  task automatic test_rresp_error();
    push_info(mk_info(1'b0, 1'b0, 8'd0, 6'd0));
    send_beat(64'hDEADBEEF_CAFEF00D, 2'b10, 1'b1);
    tests++;
    if (row_valid !== 1'b1 || row_data !== 128'hDEADBEEF_CAFEF00D || error !== 1'b1) begin
      fails++;
      $display("FAIL rresp_row: valid=%b data=%h error=%b, required 1 %h 1",
               row_valid, row_data, error, 128'hDEADBEEF_CAFEF00D);
    end
    accept_row();
    repeat (3) @(negedge clk);
    tests++;
    if (error !== 1'b1) begin
      fails++;
      $display("FAIL rresp_sticky: error=%b, required 1", error);
    end
    do_clear();
    tests++;
    if (error !== 1'b0 || txinfo_wready !== 1'b1) begin
      fails++;
      $display("FAIL rresp_clear: error=%b wready=%b, required 0 1", error, txinfo_wready);
    end
  endtask

  task automatic test_rlast_error();
    push_info(mk_info(1'b0, 1'b0, 8'd1, 6'd0));
    send_beat(64'h0000000000000001, 2'b00, 1'b1);
    tests++;
    if (error !== 1'b1 || row_valid !== 1'b0 || rready !== 1'b1) begin
      fails++;
      $display("FAIL rlast_early: error=%b valid=%b rready=%b, required 1 0 1",
               error, row_valid, rready);
    end
    send_beat(64'h0000000000000002, 2'b00, 1'b1);
    tests++;
    if (row_valid !== 1'b1 || row_data !== 128'h0000000000000002_0000000000000001) begin
      fails++;
      $display("FAIL rlast_row: valid=%b data=%h, required 1 %h",
               row_valid, row_data, 128'h0000000000000002_0000000000000001);
    end
    accept_row();
    do_clear();
  endtask

  task automatic test_overflow();
    push_info(mk_info(1'b0, 1'b0, 8'd3, 6'd0));
    send_beat(64'h1000000000000001, 2'b00, 1'b0);
    send_beat(64'h2000000000000002, 2'b00, 1'b0);
    send_beat(64'h3000000000000003, 2'b00, 1'b0);
    tests++;
    if (row_valid !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL overflow_pre: valid=%b error=%b, required 0 0", row_valid, error);
    end
    send_beat(64'h4000000000000004, 2'b00, 1'b1);
    tests++;
    if (row_valid !== 1'b1 || error !== 1'b1 ||
        row_data !== 128'h2000000000000002_1000000000000001) begin
      fails++;
      $display("FAIL overflow_row: valid=%b error=%b data=%h, required 1 1 %h",
               row_valid, error, row_data, 128'h2000000000000002_1000000000000001);
    end
    accept_row();
    do_clear();
  endtask

  task automatic test_clear_mid_collect();
    push_info(mk_info(1'b0, 1'b0, 8'd2, 6'd0));
    send_beat(64'h5555555555555555, 2'b10, 1'b0);
    tests++;
    if (error !== 1'b1) begin
      fails++;
      $display("FAIL clear_pre_error: error=%b, required 1", error);
    end
    rvalid = 1'b1;
    rdata  = 64'h6666666666666666;
    clear  = 1'b1;
    #1;
    tests++;
    if (rready !== 1'b0) begin
      fails++;
      $display("FAIL clear_rready: rready=%b, required 0", rready);
    end
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    tests++;
    if (error !== 1'b0 || row_valid !== 1'b0 || txinfo_wready !== 1'b1) begin
      fails++;
      $display("FAIL clear_state: error=%b valid=%b wready=%b, required 0 0 1",
               error, row_valid, txinfo_wready);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (rready !== 1'b0 || row_valid !== 1'b0) begin
      fails++;
      $display("FAIL clear_idle: rready=%b valid=%b, required 0 0", rready, row_valid);
    end
    rvalid = 1'b0;
    push_info(mk_info(1'b0, 1'b0, 8'd0, 6'd0));
    send_beat(64'h7777777777777777, 2'b00, 1'b1);
    tests++;
    if (row_valid !== 1'b1 || row_data !== 128'h7777777777777777 || error !== 1'b0) begin
      fails++;
      $display("FAIL clear_recover: valid=%b data=%h error=%b, required 1 %h 0",
               row_valid, row_data, error, 128'h7777777777777777);
    end
    accept_row();
  endtask

  initial begin
    rstnn         = 1'b0;
    clear         = 1'b0;
    txinfo_wvalid = 1'b0;
    txinfo_wdata  = '0;
    rvalid        = 1'b0;
    rdata         = '0;
    rresp         = 2'b00;
    rlast         = 1'b0;
    row_ready     = 1'b0;
    @(negedge clk);
    test_reset();
    test_aligned_two_beat();
    test_offset_three_beat();
    test_back_to_back();
    test_rresp_error();
    test_rlast_error();
    test_overflow();
    test_clear_mid_collect();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
